uart_rx: RTL

//  UART receiver; the receive-side counterpart of the Tx block on the same serial line.

---
 rtl/uart_rx_if.sv | 30 +++
 rtl/uart_rx.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/uart_rx_if.sv
// Serial-receive bundle between a UART receiver and its user: baud tick and RX line in,
// received byte, done strobe, framing flag and debug state out.
interface uart_rx_if #(
    parameter int DBIT = 8
);
    logic            tick;
    logic            rx;
    logic            rxDone;
    logic [DBIT-1:0] dout;
    logic            frameErr;
    logic [1:0]      state;

    modport master (
        output tick,
        output rx,
        input  rxDone,
        input  dout,
        input  frameErr,
        input  state
    );

    modport slave (
        input  tick,
        input  rx,
        output rxDone,
        output dout,
        output frameErr,
        output state
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling against an external baud tick, LSB first.
// Define UART_RX_SYNC_EN to pass RX through a 2-flop synchronizer for asynchronous pins.
module uart_rx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic     i_clk,
    input  logic     i_reset_n,
    uart_rx_if.slave bus
);
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam int SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;

    localparam logic [SW-1:0] MID_START = SW'(7);
    localparam logic [SW-1:0] LAST_DATA = SW'(15);
    localparam logic [SW-1:0] LAST_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] LAST_BIT  = NW'(DBIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } state_t;

    state_t          r_state, w_stateNext;
    logic [SW-1:0]   r_tickCnt, w_tickCntNext;
    logic [NW-1:0]   r_bitCnt, w_bitCntNext;
    logic [DBIT-1:0] r_shiftReg, w_shiftRegNext;
    logic [DBIT-1:0] r_dout, w_doutNext;
    logic            r_frameErr, w_frameErrNext;
    logic            r_rxDone, w_rxDoneNext;
    logic            w_rx;

`ifdef UART_RX_SYNC_EN
    logic [1:0] r_rxSync;

    // Reset to the idle-high level so leaving reset never looks like a start edge
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_rxSync <= 2'b11;
        end else begin
            r_rxSync <= {r_rxSync[0], bus.rx};
        end
    end

    assign w_rx = r_rxSync[1];
`else
    assign w_rx = bus.rx;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state    <= IDLE;
            r_tickCnt  <= '0;
            r_bitCnt   <= '0;
            r_shiftReg <= '0;
            r_dout     <= '0;
            r_frameErr <= 1'b0;
            r_rxDone   <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_tickCnt  <= w_tickCntNext;
            r_bitCnt   <= w_bitCntNext;
            r_shiftReg <= w_shiftRegNext;
            r_dout     <= w_doutNext;
            r_frameErr <= w_frameErrNext;
            r_rxDone   <= w_rxDoneNext;
        end
    end

    // Start detection in IDLE is per clock; every later decision waits for a baud tick
    always_comb begin
        w_stateNext    = r_state;
        w_tickCntNext  = r_tickCnt;
        w_bitCntNext   = r_bitCnt;
        w_shiftRegNext = r_shiftReg;
        w_doutNext     = r_dout;
        w_frameErrNext = r_frameErr;
        w_rxDoneNext   = 1'b0;

        case (r_state)
            IDLE: begin
                if (!w_rx) begin
                    w_stateNext   = START;
                    w_tickCntNext = '0;
                end
            end
            START: begin
                if (bus.tick) begin
                    if (r_tickCnt == MID_START) begin
                        if (!w_rx) begin
                            w_stateNext   = DATA;
                            w_tickCntNext = '0;
                            w_bitCntNext  = '0;
                        end else begin
                            w_stateNext = IDLE;
                        end
                    end else begin
                        w_tickCntNext = r_tickCnt + 1'b1;
                    end
                end
            end
            DATA: begin
                if (bus.tick) begin
                    if (r_tickCnt == LAST_DATA) begin
                        w_shiftRegNext = {w_rx, r_shiftReg[DBIT-1:1]};
                        w_tickCntNext  = '0;
                        if (r_bitCnt == LAST_BIT) begin
                            w_stateNext = STOP;
                        end else begin
                            w_bitCntNext = r_bitCnt + 1'b1;
                        end
                    end else begin
                        w_tickCntNext = r_tickCnt + 1'b1;
                    end
                end
            end
            STOP: begin
                if (bus.tick) begin
                    if (r_tickCnt == LAST_STOP) begin
                        w_doutNext     = r_shiftReg;
                        w_frameErrNext = ~w_rx;
                        w_rxDoneNext   = 1'b1;
                        w_stateNext    = IDLE;
                    end else begin
                        w_tickCntNext = r_tickCnt + 1'b1;
                    end
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    assign bus.rxDone   = r_rxDone;
    assign bus.dout     = r_dout;
    assign bus.frameErr = r_frameErr;
    assign bus.state    = r_state;
endmodule
